// File: rtl/fib_seq_gen.sv
// Fibonacci program sequencer: issues a fixed SET/INC/COPY/ADD/STORE instruction
// stream to a register-file datapath so that R0 ends up holding F(N).
module fib_seq_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] n_in,
    input  logic       instr_ready,
    output logic [2:0] opcode,
    output logic [1:0] op1,
    output logic [1:0] op2,
    output logic       instr_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT_A = 4'd1,
        S_INIT_B = 4'd2,
        S_INC_B  = 4'd3,
        S_CHK    = 4'd4,
        S_CP_T   = 4'd5,
        S_ADD    = 4'd6,
        S_CP_A   = 4'd7,
        S_STORE  = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] opcode_q, opcode_d;
    logic [1:0] op1_q, op1_d;
    logic [1:0] op2_q, op2_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       acc_s;

    assign acc_s       = valid_q & instr_ready;
    assign opcode      = opcode_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Next state and loop counter; instruction states advance only on handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT_A;
                    cnt_d   = n_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT_A: begin
                if (acc_s) state_d = S_INIT_B;
                else       state_d = S_INIT_A;
            end
            S_INIT_B: begin
                if (acc_s) state_d = S_INC_B;
                else       state_d = S_INIT_B;
            end
            S_INC_B: begin
                if (acc_s) state_d = S_CHK;
                else       state_d = S_INC_B;
            end
            S_CHK: begin
                if (cnt_q == 4'd0) state_d = S_STORE;
                else               state_d = S_CP_T;
            end
            S_CP_T: begin
                if (acc_s) state_d = S_ADD;
                else       state_d = S_CP_T;
            end
            S_ADD: begin
                if (acc_s) state_d = S_CP_A;
                else       state_d = S_ADD;
            end
            S_CP_A: begin
                if (acc_s) begin
                    state_d = S_CHK;
                    cnt_d   = cnt_q - 4'd1;
                end else begin
                    state_d = S_CP_A;
                end
            end
            S_STORE: begin
                if (acc_s) state_d = S_DONE;
                else       state_d = S_STORE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it
    always_comb begin
        opcode_d = 3'b000;
        op1_d    = 2'b00;
        op2_d    = 2'b00;
        valid_d  = 1'b0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        case (state_d)
            S_INIT_A: begin opcode_d = 3'b001; op1_d = 2'b00; op2_d = 2'b00; valid_d = 1'b1; end
            S_INIT_B: begin opcode_d = 3'b001; op1_d = 2'b01; op2_d = 2'b00; valid_d = 1'b1; end
            S_INC_B:  begin opcode_d = 3'b010; op1_d = 2'b01; op2_d = 2'b00; valid_d = 1'b1; end
            S_CP_T:   begin opcode_d = 3'b111; op1_d = 2'b10; op2_d = 2'b01; valid_d = 1'b1; end
            S_ADD:    begin opcode_d = 3'b110; op1_d = 2'b01; op2_d = 2'b00; valid_d = 1'b1; end
            S_CP_A:   begin opcode_d = 3'b111; op1_d = 2'b00; op2_d = 2'b10; valid_d = 1'b1; end
            S_STORE:  begin opcode_d = 3'b101; op1_d = 2'b00; op2_d = 2'b00; valid_d = 1'b1; end
            default:  begin opcode_d = 3'b000; op1_d = 2'b00; op2_d = 2'b00; valid_d = 1'b0; end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            opcode_q <= 3'b000;
            op1_q    <= 2'b00;
            op2_q    <= 2'b00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: expected instruction streams are queued by the
// stimulus and checked by an independent monitor that also models the register file.
module tb_fib_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] n_in;
    logic       instr_ready;
    logic [2:0] opcode;
    logic [1:0] op1;
    logic [1:0] op2;
    logic       instr_valid;
    logic       busy;
    logic       done;

    fib_seq_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_in       (n_in),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .op1        (op1),
        .op2        (op2),
        .instr_valid(instr_valid),
        .busy       (busy),
        .done       (done)
    );

    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    int          acc_cnt = 0;
    bit          rnd_mode = 1'b0;
    logic [6:0]  exp_q[$];
    logic [15:0] rf[4];

    logic [6:0]  prev_out;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_rst = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        #1;
        if (rnd_mode) instr_ready = ($urandom_range(0, 2) != 0);
        else          instr_ready = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int fib(input int n);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = b;
            b = (a + b) % 65536;
            a = t;
        end
        return a;
    endfunction

    task automatic push_prog(input int n);
        exp_q.push_back(7'b001_00_00);
        exp_q.push_back(7'b001_01_00);
        exp_q.push_back(7'b010_01_00);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(7'b111_10_01);
            exp_q.push_back(7'b110_01_00);
            exp_q.push_back(7'b111_00_10);
        end
        exp_q.push_back(7'b101_00_00);
    endtask

    // Monitor: compares every accepted instruction, executes it on the model, checks stall stability
    always @(negedge clk) begin
        logic [6:0] cur;
        logic [6:0] want;
        cur = {opcode, op1, op2};
        if (!rst && !prev_rst && prev_valid && !prev_ready) begin
            check("stall_stable", int'({instr_valid, cur}), int'({1'b1, prev_out}));
        end
        if (!rst && instr_valid && instr_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_instr", int'(cur), -1);
            end else begin
                want = exp_q.pop_front();
                check("instr", int'(cur), int'(want));
            end
            case (opcode)
                3'b001: rf[op1] = 16'd0;
                3'b010: rf[op1] = rf[op1] + 16'd1;
                3'b011: rf[op1] = rf[op1] - 16'd1;
                3'b110: rf[op1] = rf[op1] + rf[op2];
                3'b111: rf[op1] = rf[op2];
                default: ;
            endcase
        end
        prev_out   = cur;
        prev_valid = instr_valid;
        prev_ready = instr_ready;
        prev_rst   = rst;
    end

    task automatic run(input int n, input bit rnd, input bit poke);
        int ks;
        int acc0;
        int w;
        push_prog(n);
        acc0     = acc_cnt;
        rnd_mode = rnd;
        n_in     = 4'(n);
        start    = 1'b1;
        @(negedge clk);
        ks    = edge_cnt;
        start = 1'b0;
        n_in  = 4'(15 - n);
        if (poke) begin
            @(negedge clk);
            start = 1'b1;
            n_in  = 4'd9;
            @(negedge clk);
            start = 1'b0;
        end
        w = 0;
        while (!done && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", int'(done), 1);
        if (!rnd) check("done_latency", edge_cnt - ks, 5 + 4 * n);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("instr_count", acc_cnt - acc0, 4 + 3 * n);
        check("r0_result", int'(rf[0]), fib(n));
        check("queue_drained", exp_q.size(), 0);
        rnd_mode = 1'b0;
    endtask

    initial begin
        int w;
        rst   = 1'b1;
        start = 1'b0;
        n_in  = 4'd0;
        for (int i = 0; i < 4; i++) rf[i] = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_outputs", int'({opcode, op1, op2, instr_valid, busy, done}), 0);
        check("rst_cnt", int'(dut.cnt_q), 0);
        rst = 1'b0;
        @(negedge clk);

        run(0, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);
        run(5, 1'b1, 1'b0);
        run(2, 1'b0, 1'b1);

        // Abort an N=7 program while ADD is on the bus
        push_prog(7);
        n_in  = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (opcode != 3'b110 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("saw_add", int'(opcode), 6);
        #1 rst = 1'b1;
        #1;
        check("abort_outputs", int'({opcode, op1, op2, instr_valid, busy, done}), 0);
        check("abort_cnt", int'(dut.cnt_q), 0);
        check("abort_state", int'(dut.state_q), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(1, 1'b0, 1'b0);

        run(15, 1'b0, 1'b0);
        check("cnt_final", int'(dut.cnt_q), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
